// File: rtl/mux_share_arbiter_if.sv
// mux_share_arbiter_if: request/data/grant bundle between two requesters and the shared-mux arbiter (stats signals present under ARB_STATS_EN)
interface mux_share_arbiter_if #(parameter int W = 1);
    logic         req0;
    logic         req1;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         gnt0;
    logic         gnt1;
    logic         sel;
    logic [W-1:0] data_out;
    logic         out_valid;
`ifdef ARB_STATS_EN
    logic [7:0]   gcnt0;
    logic [7:0]   gcnt1;
    modport master (output req0, req1, in0, in1, input gnt0, gnt1, sel, data_out, out_valid, gcnt0, gcnt1);
    modport slave  (input req0, req1, in0, in1, output gnt0, gnt1, sel, data_out, out_valid, gcnt0, gcnt1);
`else
    modport master (output req0, req1, in0, in1, input gnt0, gnt1, sel, data_out, out_valid);
    modport slave  (input req0, req1, in0, in1, output gnt0, gnt1, sel, data_out, out_valid);
`endif
endinterface

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: two-way round-robin arbiter with bounded tenure driving a shared 2:1 mux and a registered output; ARB_STATS_EN adds grant-entry counters
module mux_share_arbiter #(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4
) (
    input logic               clock,
    input logic               reset,
    mux_share_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] G0   = 2'd1;
    localparam logic [1:0] G1   = 2'd2;
    localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);

    logic [1:0]   state_q, state_d;
    logic [7:0]   hold_q, hold_d;
    logic         prio_q, prio_d;
    logic         sel_q, sel_d;
    logic         valid_q;
    logic [W-1:0] data_q;
    logic         at_last;
    logic         entry;

    // next grant state, tenure counter, tie-break owner and mux select
    always_comb begin
        at_last = hold_q == LAST;
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = (bus.req0 & bus.req1) ? (prio_q ? G1 : G0) : bus.req0 ? G0 : bus.req1 ? G1 : IDLE;
            G0:      state_d = !bus.req0 ? (bus.req1 ? G1 : IDLE) : (at_last & bus.req1) ? G1 : G0;
            G1:      state_d = !bus.req1 ? (bus.req0 ? G0 : IDLE) : (at_last & bus.req0) ? G0 : G1;
            default: state_d = IDLE;
        endcase
        entry  = (state_d != IDLE) && (state_d != state_q);
        hold_d = (state_d == IDLE || entry || at_last) ? 8'd0 : hold_q + 8'd1;
        prio_d = entry ? (state_d == G0) : prio_q;
        sel_d  = (state_d == G1) ? 1'b1 : (state_d == G0) ? 1'b0 : sel_q;
    end

    // arbiter state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
            prio_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    // capture the granted source one cycle after the grant; hold data when idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= state_q != IDLE;
            if (state_q != IDLE) data_q <= sel_q ? bus.in1 : bus.in0;
        end
    end

    assign bus.gnt0      = state_q == G0;
    assign bus.gnt1      = state_q == G1;
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid_q;
    assign bus.data_out  = data_q;

`ifdef ARB_STATS_EN
    logic [7:0] gcnt0_q, gcnt1_q;

    // saturating count of grant entries per requester
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gcnt0_q <= 8'd0;
            gcnt1_q <= 8'd0;
        end else begin
            if (entry && state_d == G0 && gcnt0_q != 8'hFF) gcnt0_q <= gcnt0_q + 8'd1;
            if (entry && state_d == G1 && gcnt1_q != 8'hFF) gcnt1_q <= gcnt1_q + 8'd1;
        end
    end

    assign bus.gcnt0 = gcnt0_q;
    assign bus.gcnt1 = gcnt1_q;
`endif
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed vector bench for mux_share_arbiter (MAX_HOLD=4 main instance, MAX_HOLD=1 companion)
module tb_mux_share_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mux_share_arbiter_if #(.W(1)) bus4 ();
    mux_share_arbiter_if #(.W(1)) bus1 ();

    mux_share_arbiter #(.W(1), .MAX_HOLD(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));
    mux_share_arbiter #(.W(1), .MAX_HOLD(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    typedef struct {
        logic r0, r1, i0, i1;
        logic g0, g1, s, v, d;
        logic h1g0;
    } vec_t;

    vec_t va [8];
    vec_t vb [17];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic i0, input logic i1);
        bus4.req0 = r0; bus4.req1 = r1; bus4.in0 = i0; bus4.in1 = i1;
        bus1.req0 = r0; bus1.req1 = r1; bus1.in0 = i0; bus1.in1 = i1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".gnt0"}, 8'(bus4.gnt0), 8'd0);
        check({tag, ".gnt1"}, 8'(bus4.gnt1), 8'd0);
        check({tag, ".sel"}, 8'(bus4.sel), 8'd0);
        check({tag, ".out_valid"}, 8'(bus4.out_valid), 8'd0);
        check({tag, ".data_out"}, 8'(bus4.data_out), 8'd0);
    endtask

    task automatic run_vec(input string tag, input int idx, input vec_t t);
        drive(t.r0, t.r1, t.i0, t.i1);
        step();
        check($sformatf("%s%0d.gnt0", tag, idx), 8'(bus4.gnt0), 8'(t.g0));
        check($sformatf("%s%0d.gnt1", tag, idx), 8'(bus4.gnt1), 8'(t.g1));
        check($sformatf("%s%0d.sel", tag, idx), 8'(bus4.sel), 8'(t.s));
        check($sformatf("%s%0d.out_valid", tag, idx), 8'(bus4.out_valid), 8'(t.v));
        check($sformatf("%s%0d.data_out", tag, idx), 8'(bus4.data_out), 8'(t.d));
        check($sformatf("%s%0d.h1_gnt0", tag, idx), 8'(bus1.gnt0), 8'(t.h1g0));
        check($sformatf("%s%0d.h1_onehot", tag, idx), 8'(bus1.gnt0 & bus1.gnt1), 8'd0);
    endtask

    initial begin
        // req0 alone with in0=1: grant after one edge, data after two, no forced switch; then both drop
        va[0] = '{1,0,1,0, 1,0,0,0,0, 1};
        va[1] = '{1,0,1,0, 1,0,0,1,1, 1};
        va[2] = '{1,0,1,0, 1,0,0,1,1, 1};
        va[3] = '{1,0,1,0, 1,0,0,1,1, 1};
        va[4] = '{1,0,1,0, 1,0,0,1,1, 1};
        va[5] = '{1,0,1,0, 1,0,0,1,1, 1};
        va[6] = '{0,0,1,0, 0,0,0,1,1, 0};
        va[7] = '{0,0,1,0, 0,0,0,0,1, 0};
        // both requesting from reset: 4-cycle tenures; then req1 drops in G1, then both drop
        vb[0]  = '{1,1,0,1, 1,0,0,0,0, 1};
        vb[1]  = '{1,1,0,1, 1,0,0,1,0, 0};
        vb[2]  = '{1,1,0,1, 1,0,0,1,0, 1};
        vb[3]  = '{1,1,0,1, 1,0,0,1,0, 0};
        vb[4]  = '{1,1,0,1, 0,1,1,1,0, 1};
        vb[5]  = '{1,1,0,1, 0,1,1,1,1, 0};
        vb[6]  = '{1,1,0,1, 0,1,1,1,1, 1};
        vb[7]  = '{1,1,0,1, 0,1,1,1,1, 0};
        vb[8]  = '{1,1,0,1, 1,0,0,1,1, 1};
        vb[9]  = '{1,1,0,1, 1,0,0,1,0, 0};
        vb[10] = '{1,1,0,1, 1,0,0,1,0, 1};
        vb[11] = '{1,1,0,1, 1,0,0,1,0, 0};
        vb[12] = '{1,1,0,1, 0,1,1,1,0, 1};
        vb[13] = '{1,0,0,1, 1,0,0,1,1, 1};
        vb[14] = '{1,0,0,1, 1,0,0,1,0, 1};
        vb[15] = '{0,0,0,1, 0,0,0,1,0, 0};
        vb[16] = '{0,0,0,1, 0,0,0,0,0, 0};

        drive(1, 0, 1, 0);
        #3 reset = 1'b1;
        #1 check_zero("rst_t3");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec("A", i, va[i]);

        drive(1, 0, 1, 0);
        step();
        check("pre_rst.gnt0", 8'(bus4.gnt0), 8'd1);
        check("pre_rst.data_out", 8'(bus4.data_out), 8'd1);
        #3 reset = 1'b1;
        #1 check_zero("rst_mid_grant");
        check("rst_mid_grant.h1_gnt0", 8'(bus1.gnt0), 8'd0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) run_vec("B", i, vb[i]);

`ifdef ARB_STATS_EN
        check("gcnt0", bus4.gcnt0, 8'd3);
        check("gcnt1", bus4.gcnt1, 8'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
